// File: rtl/vr_fifo.sv
// -----------------------------------------------------------------------------
// vr_fifo
// -----------------------------------------------------------------------------
// Synchronous valid/ready FIFO with first-word-fall-through output. It sits
// between the packet producer and consumer stages so that producer bursts are
// absorbed while the consumer applies back-pressure.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of entries, power of two, >= 2
//   CW     count width, $clog2(DEPTH)+1 (derived, not overridable)
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   synchronous reset, active high
//   in_valid      in   upstream offers in_data
//   in_ready      out  FIFO can accept a word this cycle
//   in_data       in   upstream data word
//   out_valid     out  head entry available
//   out_ready     in   downstream accepts the head entry this cycle
//   out_data      out  head entry (don't-care while out_valid = 0)
//   count         out  current occupancy, 0..DEPTH
//
// Optional feature (macro VR_FIFO_STATS_EN)
//   stall_in_cnt  out  cycles with in_valid && !in_ready, saturating 16 bits
//   stall_out_cnt out  cycles with out_ready && !out_valid, saturating 16 bits
// -----------------------------------------------------------------------------
module vr_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
`ifdef VR_FIFO_STATS_EN
    ,
    output logic [15:0]      stall_in_cnt,
    output logic [15:0]      stall_out_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Flags come from the registered count only, so there is no combinational
    // path from out_ready to in_ready or from in_valid to out_valid.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // First-word-fall-through: the head entry is read combinationally.
    assign out_data  = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define which
    // entries are live, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef VR_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && stall_in_cnt != 16'hFFFF) begin
                stall_in_cnt <= stall_in_cnt + 16'd1;
            end
            if (out_ready && !out_valid && stall_out_cnt != 16'hFFFF) begin
                stall_out_cnt <= stall_out_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
